ip_match_ctrl: RTL and testbench

Sequencing controller for a bank of `ip_comparator` instances in the sniffer datapath. It holds the flagged-IP table and clears the comparators at each start of packet. It gates only the IP-address window of each packet onto the comparator data bus, waits out comparator latency, and reports matching table entries to the alert logic through a valid/ready handshake.

---
 rtl/ip_match_ctrl.sv | 143 ++++++++++++++
 tb/tb_ip_match_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_match_ctrl.sv
// Sequencer for a bank of ip_comparator instances: owns the flagged-IP table,
// gates the address window onto the comparator bus and reports matches.
//
// state  | meaning
// IDLE   | waiting for sop; table writes allowed
// SCAN   | packet in flight, window words forwarded to comparators
// DRAIN  | waiting out comparator latency after eop
// REPORT | alert held until alert_ready
module ip_match_ctrl #(
   parameter int NUM_IPS   = 4,
   parameter int WIN_START = 6,
   parameter int WIN_LEN   = 3,
   parameter int COMP_LAT  = 3,
   localparam int AW = (NUM_IPS > 1) ? $clog2(NUM_IPS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             data_in,
   input  logic                    data_valid,
   input  logic                    sop,
   input  logic                    eop,
   output logic                    in_ready,
   input  logic                    cfg_we,
   input  logic [AW-1:0]           cfg_addr,
   input  logic [31:0]             cfg_ip,
   input  logic                    cfg_en,
   output logic                    cfg_ready,
   output logic [32*NUM_IPS-1:0]   flagged_ip,
   output logic                    comp_clear,
   output logic [31:0]             comp_data,
   input  logic [NUM_IPS-1:0]      comp_match,
   output logic                    alert_valid,
   input  logic                    alert_ready,
   output logic [AW-1:0]           alert_idx,
   output logic [NUM_IPS-1:0]      alert_mask
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

   localparam logic [7:0] WIN_LO     = 8'(WIN_START);
   localparam logic [7:0] WIN_HI     = 8'(WIN_START + WIN_LEN);
   localparam logic [7:0] DRAIN_LOAD = 8'(COMP_LAT);

   state_t               state_q, state_d;
   logic [NUM_IPS-1:0]   en_tab;
   logic [NUM_IPS-1:0]   acc, acc_nxt;
   logic [7:0]           word_cnt;
   logic [7:0]           drain_cnt;
   logic                 clr_d1;
   logic                 beat;
   logic                 in_win;
   logic                 cfg_wr;
   logic [AW-1:0]        idx_lo;

   assign in_ready  = !rst && (state_q == IDLE || state_q == SCAN);
   assign cfg_ready = !rst && (state_q == IDLE);
   assign beat      = data_valid && in_ready;
   assign cfg_wr    = cfg_we && cfg_ready;
   assign in_win    = (word_cnt >= WIN_LO) && (word_cnt < WIN_HI);

   // Comparator outputs are stale for two cycles after a clear, so they are masked then.
   always_comb begin
      acc_nxt = acc;
      if (beat && sop)
         acc_nxt = '0;
      else if ((state_q == SCAN || state_q == DRAIN) && !comp_clear && !clr_d1)
         acc_nxt = acc | (comp_match & en_tab);
   end

   always_comb begin
      state_d     = state_q;
      alert_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (beat && sop)
               state_d = eop ? DRAIN : SCAN;
         end
         SCAN: begin
            if (beat && eop)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == 8'd0)
               state_d = (acc_nxt != '0) ? REPORT : IDLE;
         end
         REPORT: begin
            alert_valid = 1'b1;
            if (alert_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      idx_lo = '0;
      for (int i = NUM_IPS - 1; i >= 0; i--)
         if (acc[i])
            idx_lo = AW'(i);
   end

   assign alert_idx  = (state_q == REPORT) ? idx_lo : '0;
   assign alert_mask = (state_q == REPORT) ? acc : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         flagged_ip <= '0;
         en_tab     <= '0;
         acc        <= '0;
         word_cnt   <= '0;
         drain_cnt  <= DRAIN_LOAD;
         comp_clear <= 1'b0;
         clr_d1     <= 1'b0;
         comp_data  <= '0;
      end else begin
         state_q    <= state_d;
         acc        <= acc_nxt;
         comp_clear <= beat && sop;
         clr_d1     <= comp_clear;
         comp_data  <= (beat && !sop && state_q == SCAN && in_win) ? data_in : 32'h0;

         if (beat && sop)
            word_cnt <= 8'd1;
         else if (beat && state_q == SCAN && word_cnt != 8'hFF)
            word_cnt <= word_cnt + 8'd1;

         // Down-counter preloaded outside DRAIN; terminal count ends the drain.
         if (state_q == DRAIN && drain_cnt != 8'd0)
            drain_cnt <= drain_cnt - 8'd1;
         else
            drain_cnt <= DRAIN_LOAD;

         for (int i = 0; i < NUM_IPS; i++) begin
            if (cfg_wr && cfg_addr == AW'(i)) begin
               flagged_ip[32*i +: 32] <= cfg_ip;
               en_tab[i]              <= cfg_en;
            end
         end
      end
   end

endmodule

// File: tb/tb_ip_match_ctrl.sv
// Scoreboard bench for ip_match_ctrl: directed packets, a sticky comparator
// model, and a negedge monitor that checks comp_data, comp_clear and alerts.
module tb_ip_match_ctrl;

   logic         clk;
   logic         rst;
   logic [31:0]  data_in;
   logic         data_valid, sop, eop;
   logic         in_ready;
   logic         cfg_we;
   logic [1:0]   cfg_addr;
   logic [31:0]  cfg_ip;
   logic         cfg_en;
   logic         cfg_ready;
   logic [127:0] flagged_ip;
   logic         comp_clear;
   logic [31:0]  comp_data;
   logic [3:0]   comp_match;
   logic         alert_valid, alert_ready;
   logic [1:0]   alert_idx;
   logic [3:0]   alert_mask;

   ip_match_ctrl #(.NUM_IPS(4), .WIN_START(6), .WIN_LEN(3), .COMP_LAT(3)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .sop(sop), .eop(eop), .in_ready(in_ready), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_ip(cfg_ip), .cfg_en(cfg_en),
      .cfg_ready(cfg_ready), .flagged_ip(flagged_ip), .comp_clear(comp_clear),
      .comp_data(comp_data), .comp_match(comp_match), .alert_valid(alert_valid),
      .alert_ready(alert_ready), .alert_idx(alert_idx), .alert_mask(alert_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int eop_cyc = 0;
   int alerts_seen = 0;

   typedef struct {
      logic [1:0] idx;
      logic [3:0] mask;
      int         at;
   } alert_t;

   alert_t      exp_alert[$];
   logic [31:0] exp_data[$];

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Comparator model: matches an IP split across two consecutive words
   // (low half of one word, high half of the next), sticky until cleared.
   logic [31:0] prev_cd;
   logic [3:0]  hit, dl0, dl1, dl2, sticky;

   always_comb begin
      hit = '0;
      for (int i = 0; i < 4; i++)
         hit[i] = (flagged_ip[32*i +: 32] != 32'h0) &&
                  ({prev_cd[15:0], comp_data[31:16]} == flagged_ip[32*i +: 32]);
   end

   always @(posedge clk) begin
      prev_cd <= comp_data;
      if (rst || comp_clear) begin
         dl0 <= '0; dl1 <= '0; dl2 <= '0; sticky <= '0;
      end else begin
         dl0 <= hit; dl1 <= dl0; dl2 <= dl1; sticky <= sticky | dl2;
      end
   end
   assign comp_match = sticky;

   // Monitor
   logic       pend_fire = 1'b0, pend_sop = 1'b0, prev_valid = 1'b0;
   logic [1:0] prev_idx  = '0;
   logic [3:0] prev_mask = '0;

   always @(negedge clk) begin
      alert_t a;
      logic [31:0] d;
      if (pend_fire) begin
         if (exp_data.size() == 0) chk("comp_data_unexpected_beat", 1, 0);
         else begin
            d = exp_data.pop_front();
            chk("comp_data", comp_data, d);
         end
      end else if (comp_data != 32'h0) begin
         chk("comp_data_idle", comp_data, 0);
      end
      if (pend_sop || comp_clear) chk("comp_clear", comp_clear, pend_sop);
      if (alert_valid === 1'b1 && !prev_valid) begin
         alerts_seen <= alerts_seen + 1;
         if (exp_alert.size() == 0) chk("unexpected_alert", 1, 0);
         else begin
            a = exp_alert.pop_front();
            chk("alert_idx", alert_idx, a.idx);
            chk("alert_mask", alert_mask, a.mask);
            chk("alert_cycle", cyc, a.at);
         end
      end else if (alert_valid === 1'b1 && prev_valid) begin
         chk("alert_idx_stable", alert_idx, prev_idx);
         chk("alert_mask_stable", alert_mask, prev_mask);
      end
      pend_fire  <= (data_valid && in_ready === 1'b1);
      pend_sop   <= (data_valid && in_ready === 1'b1 && sop);
      prev_valid <= (alert_valid === 1'b1);
      prev_idx   <= alert_idx;
      prev_mask  <= alert_mask;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] ip, input logic en);
      cfg_we = 1'b1; cfg_addr = a; cfg_ip = ip; cfg_en = en;
      tick();
      cfg_we = 1'b0; cfg_addr = '0; cfg_ip = '0; cfg_en = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                            input logic [31:0] exp_cd);
      data_in = d; sop = s; eop = e; data_valid = 1'b1;
      if (e) eop_cyc = cyc;
      exp_data.push_back(exp_cd);
      tick();
      data_valid = 1'b0; sop = 1'b0; eop = 1'b0; data_in = '0;
   endtask

   task automatic send_pkt(input int n, input logic [31:0] w6, input logic [31:0] w7,
                           input bit with_eop);
      logic [31:0] w;
      for (int i = 0; i < n; i++) begin
         w = (i == 6) ? w6 : (i == 7) ? w7 : (32'hA500_0000 | 32'(i));
         send_beat(w, i == 0, with_eop && (i == n - 1), (i >= 6 && i < 9) ? w : 32'h0);
      end
   endtask

   task automatic push_alert(input logic [1:0] idx, input logic [3:0] mask, input int at);
      alert_t a;
      a.idx = idx; a.mask = mask; a.at = at;
      exp_alert.push_back(a);
   endtask

   task automatic wait_alert(input string name);
      int n;
      n = 0;
      while (alert_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(name, alert_valid, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int seen;
      rst = 1'b1; data_in = '0; data_valid = 1'b0; sop = 1'b0; eop = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_ip = '0; cfg_en = 1'b0; alert_ready = 1'b0;

      // Reset held for two cycles
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_alert_valid", alert_valid, 0);
      chk("rst_comp_clear", comp_clear, 0);
      chk("rst_comp_data", comp_data, 0);
      chk("rst_flagged_ip", flagged_ip, 0);
      chk("rst_alert_mask", alert_mask, 0);
      chk("rst_alert_idx", alert_idx, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_cfg_ready", cfg_ready, 1);

      // Single match on entry 0, alert held off for three cycles
      cfg_write(2'd0, 32'hC0A8_0101, 1'b1);
      chk("table_entry0", flagged_ip[31:0], 32'hC0A8_0101);
      send_pkt(10, 32'h0000_C0A8, 32'h0101_0000, 1'b1);
      push_alert(2'd0, 4'b0001, eop_cyc + 5);
      wait_alert("single_alert_timeout");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_in_ready", in_ready, 0);
         chk("hold_alert_valid", alert_valid, 1);
      end
      alert_ready = 1'b1;
      tick();
      alert_ready = 1'b0;
      chk("after_hs_alert_valid", alert_valid, 0);
      chk("after_hs_in_ready", in_ready, 1);

      // Entries 1 and 3 match, entry 1 disabled; config write during DRAIN dropped
      cfg_write(2'd1, 32'h0A00_0005, 1'b0);
      cfg_write(2'd3, 32'h0A00_0005, 1'b1);
      alert_ready = 1'b1;
      send_pkt(10, 32'h0000_0A00, 32'h0005_0000, 1'b1);
      push_alert(2'd3, 4'b1000, eop_cyc + 5);
      chk("drain_cfg_ready", cfg_ready, 0);
      chk("drain_in_ready", in_ready, 0);
      cfg_write(2'd2, 32'hDEAD_BEEF, 1'b1);
      wait_alert("multi_alert_timeout");
      tick();
      chk("multi_after_alert_valid", alert_valid, 0);
      chk("multi_after_in_ready", in_ready, 1);
      chk("drain_write_dropped", flagged_ip[95:64], 32'h0);
      chk("table_entry3", flagged_ip[127:96], 32'h0A00_0005);

      // Abort: first packet matches entry 0, then a fresh sop mid-packet
      seen = alerts_seen;
      send_pkt(15, 32'h0000_C0A8, 32'h0101_0000, 1'b0);
      send_pkt(10, 32'h5555_0000, 32'h6666_0000, 1'b1);
      repeat (10) tick();
      chk("abort_no_alert", alerts_seen, seen);
      chk("abort_idle_in_ready", in_ready, 1);

      // Single-beat packet
      send_beat(32'h1234_5678, 1'b1, 1'b1, 32'h0);
      chk("single_beat_drain", in_ready, 0);
      repeat (3) tick();
      chk("single_beat_drain_end", in_ready, 0);
      tick();
      chk("single_beat_idle", in_ready, 1);
      repeat (4) tick();
      chk("single_beat_no_alert", alerts_seen, seen);

      // Reset while an alert is pending
      alert_ready = 1'b0;
      send_pkt(10, 32'h0000_C0A8, 32'h0101_0000, 1'b1);
      push_alert(2'd0, 4'b0001, eop_cyc + 5);
      wait_alert("rst_report_alert_timeout");
      tick();
      chk("rst_report_valid_before", alert_valid, 1);
      rst = 1'b1;
      tick();
      chk("rst_report_alert_valid", alert_valid, 0);
      chk("rst_report_in_ready", in_ready, 0);
      chk("rst_report_table", flagged_ip, 0);
      rst = 1'b0;
      #1;
      chk("rst_report_idle_ready", in_ready, 1);
      chk("rst_report_cfg_ready", cfg_ready, 1);

      repeat (3) tick();
      chk("data_queue_empty", exp_data.size(), 0);
      chk("alert_queue_empty", exp_alert.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
